// File: rtl/fir_l2_output_serializer.sv
// Output end of the 2-parallel FIR: rounds/saturates each lane to an audio sample,
// buffers pairs in a small FIFO and replays them one sample per clock in time order.
module fir_l2_output_serializer #(
    parameter int unsigned IN_WIDTH   = 64,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned SHIFT      = 23,
    parameter int unsigned PAIR_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  data_in_1,
    input  logic signed [IN_WIDTH-1:0]  data_in_2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        sat_flag,
    output logic [15:0]                 sat_count
);

    localparam int unsigned PW = (PAIR_DEPTH > 1) ? $clog2(PAIR_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = IN_WIDTH + 1;

    localparam logic signed [TW-1:0] RND  = signed'(TW'(1) << (SHIFT - 1));
    localparam logic signed [TW-1:0] QMAX = signed'(TW'((2 ** (OUT_WIDTH - 1)) - 1));
    localparam logic signed [TW-1:0] QMIN = ~QMAX;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] lane2;
        logic [OUT_WIDTH-1:0] lane1;
    } pair_t;

    // Returns {saturated, sample}: round-half-up, arithmetic shift, clamp.
    function automatic logic [OUT_WIDTH:0] quant(input logic [IN_WIDTH-1:0] x);
        logic signed [TW-1:0] t;
        logic signed [TW-1:0] q;
        t = signed'({x[IN_WIDTH-1], x}) + RND;
        q = t >>> SHIFT;
        if (q > QMAX) begin
            quant = {1'b1, QMAX[OUT_WIDTH-1:0]};
        end else if (q < QMIN) begin
            quant = {1'b1, QMIN[OUT_WIDTH-1:0]};
        end else begin
            quant = {1'b0, q[OUT_WIDTH-1:0]};
        end
    endfunction

    pair_t           mem [PAIR_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            lane_sel;

    logic [OUT_WIDTH:0] q1;
    logic [OUT_WIDTH:0] q2;
    logic [1:0]         nsat;
    logic [16:0]        sat_sum;
    logic               push;
    logic               take;
    logic               pop;
    pair_t              head;

    always_comb begin
        q1      = quant(data_in_1);
        q2      = quant(data_in_2);
        nsat    = 2'(q1[OUT_WIDTH]) + 2'(q2[OUT_WIDTH]);
        sat_sum = {1'b0, sat_count} + 17'(nsat);
    end

    // Ready is held low for as long as reset is applied.
    assign in_ready  = !reset && (count < CW'(PAIR_DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    assign pop       = take && lane_sel;
    assign head      = mem[rd_ptr];
    assign data_out  = signed'(lane_sel ? head.lane2 : head.lane1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(PAIR_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            lane_sel  <= 1'b0;
            sat_flag  <= 1'b0;
            sat_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{lane2: q2[OUT_WIDTH-1:0], lane1: q1[OUT_WIDTH-1:0]};
                wr_ptr      <= wr_ptr + PW'(1);
                if (nsat != 2'd0) begin
                    sat_flag  <= 1'b1;
                    sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (take) begin
                lane_sel <= ~lane_sel;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
